pc_ir_unit: RTL

Program-counter and instruction-register stage of `mycpu`, directly upstream of the control unit. It holds the PC that addresses instruction memory, captures the fetched word into the IR when the control unit asserts `il`, and presents the IR to the control unit. It applies the control unit's `ps` code each cycle (hold, increment, relative branch, register jump) and keeps a retired-fetch counter for the testbench and debug.

---
 rtl/mycpu_pkg.sv | 37 +++
 rtl/pc_ir_unit_if.sv | 37 +++
 rtl/pc_ir_unit_pc_next.sv | 33 +++
 rtl/pc_ir_unit.sv | 63 ++++++
 4 files changed

// File: rtl/mycpu_pkg.sv
// mycpu_pkg: shared types and helpers for the mycpu datapath/control slice.
//   ps_t        - PC select code driven by the control unit.
//   IR field    - bit positions of opcode, DR, SA and SB/OP in the 16-bit IR.
//   sext6       - sign-extends a 6-bit two's-complement value.
//   br_offs_fld - extracts the split branch offset {DR, SB} from an IR word.
package mycpu_pkg;

  typedef enum logic [1:0] {
    PS_HOLD = 2'b00,
    PS_INC  = 2'b01,
    PS_BR   = 2'b10,
    PS_JMP  = 2'b11
  } ps_t;

  localparam int unsigned IR_W    = 16;
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 9;
  localparam int unsigned DR_MSB  = 8;
  localparam int unsigned DR_LSB  = 6;
  localparam int unsigned SA_MSB  = 5;
  localparam int unsigned SA_LSB  = 3;
  localparam int unsigned SB_MSB  = 2;
  localparam int unsigned SB_LSB  = 0;

  // Widest address the sign-extension helper serves; callers cast down to AW.
  localparam int unsigned SEXT_W = 64;

  function automatic logic [SEXT_W-1:0] sext6(input logic [5:0] v);
    return {{(SEXT_W-6){v[5]}}, v};
  endfunction

  // The branch offset is split across the DR and SB fields of the IR.
  function automatic logic [5:0] br_offs_fld(input logic [IR_W-1:0] ir);
    return {ir[DR_MSB:DR_LSB], ir[SB_MSB:SB_LSB]};
  endfunction

endpackage

// File: rtl/pc_ir_unit_if.sv
// pc_ir_if: bus between the control unit / instruction memory side (master)
// and the PC/IR stage (slave).
//   ps_in         - PC select (00 hold, 01 inc, 10 branch, 11 jump)
//   il_in         - instruction load strobe
//   imem_in       - instruction word read at pc_out
//   a_in          - register-file A bus, jump target
//   pc_out        - current PC / instruction memory address
//   ins_out       - current IR
//   imm_out       - zero-extended OP field of the IR
//   offs_out      - sign-extended split branch offset of the IR
//   fetch_cnt_out - IR loads since reset
interface pc_ir_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned CW = 32
);

  logic [1:0]    ps_in;
  logic          il_in;
  logic [15:0]   imem_in;
  logic [AW-1:0] a_in;
  logic [AW-1:0] pc_out;
  logic [15:0]   ins_out;
  logic [15:0]   imm_out;
  logic [AW-1:0] offs_out;
  logic [CW-1:0] fetch_cnt_out;

  modport master (
    output ps_in, il_in, imem_in, a_in,
    input  pc_out, ins_out, imm_out, offs_out, fetch_cnt_out
  );

  modport slave (
    input  ps_in, il_in, imem_in, a_in,
    output pc_out, ins_out, imm_out, offs_out, fetch_cnt_out
  );

endinterface

// File: rtl/pc_ir_unit_pc_next.sv
// pc_next: combinational next-PC selection for the PC/IR stage.
//   ps      - PC select code
//   pc      - current PC
//   offs    - sign-extended branch offset (already AW bits)
//   a       - jump target from the register file
//   next_pc - PC value to load on the next edge (modulo 2^AW)
module pc_next
  import mycpu_pkg::*;
#(
  parameter int unsigned AW = 16
) (
  input  logic [1:0]    ps,
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] offs,
  input  logic [AW-1:0] a,
  output logic [AW-1:0] next_pc
);

  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  // Select hold / increment / relative branch / register jump; adds wrap silently.
  always_comb begin
    next_pc = pc;
    case (ps_t'(ps))
      PS_HOLD: next_pc = pc;
      PS_INC:  next_pc = pc + ONE;
      PS_BR:   next_pc = pc + offs;
      PS_JMP:  next_pc = a;
      default: next_pc = pc;
    endcase
  end

endmodule

// File: rtl/pc_ir_unit.sv
// pc_ir_unit: program counter and instruction register stage of mycpu.
//   clk, rst - clock and synchronous active-high reset
//   bus      - pc_ir_if slave: ps/il/imem/a inputs from the control unit and
//              memory; pc/ins/imm/offs/fetch_cnt outputs.
// The PC is updated every edge from ps_in; the IR captures imem_in (the word
// at the current, not yet updated, PC) when il_in is high. Branch offsets are
// relative to the branch instruction's own address.
module pc_ir_unit
  import mycpu_pkg::*;
#(
  parameter int unsigned   AW           = 16,
  parameter logic [AW-1:0] RESET_VECTOR = '0,
  parameter int unsigned   CW           = 32
) (
  input logic      clk,
  input logic      rst,
  pc_ir_if.slave   bus
);

  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [AW-1:0]   pc_r;
  logic [IR_W-1:0] ir_r;
  logic [CW-1:0]   fetch_cnt_r;
  logic [AW-1:0]   next_pc_s;
  logic [AW-1:0]   offs_s;

  // Offset and immediate come only from the IR, never from imem_in.
  assign offs_s = AW'(sext6(br_offs_fld(ir_r)));

  pc_next #(.AW(AW)) u_pc_next (
    .ps      (bus.ps_in),
    .pc      (pc_r),
    .offs    (offs_s),
    .a       (bus.a_in),
    .next_pc (next_pc_s)
  );

  // PC, IR and fetch counter; reset overrides any pending ps/il action.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r        <= RESET_VECTOR;
      ir_r        <= 16'h0000;
      fetch_cnt_r <= {CW{1'b0}};
    end else begin
      pc_r <= next_pc_s;
      if (bus.il_in) begin
        ir_r        <= bus.imem_in;
        fetch_cnt_r <= fetch_cnt_r + CNT_ONE;
      end else begin
        ir_r        <= ir_r;
        fetch_cnt_r <= fetch_cnt_r;
      end
    end
  end

  assign bus.pc_out        = pc_r;
  assign bus.ins_out       = ir_r;
  assign bus.imm_out       = {13'b0, ir_r[SB_MSB:SB_LSB]};
  assign bus.offs_out      = offs_s;
  assign bus.fetch_cnt_out = fetch_cnt_r;

endmodule
